// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: valid/ready handshake over a 2-entry skid buffer,
// with stall/mem-stall hold, flush-to-bubble, optional zero squashing and a flush counter.
module pipe_stage_buf #(
    parameter int                DATA_W    = 32,
    parameter int                PC_W      = 32,
    parameter logic [DATA_W-1:0] BUBBLE    = '0,
    parameter bit                DROP_ZERO = 1'b1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              down_valid_o,
    input  logic              down_ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [PC_W-1:0]   pc_o,
    input  logic              stall_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              valid_r;
    logic              up_ready_r;
    logic [DATA_W-1:0] main_data_r;
    logic [PC_W-1:0]   main_pc_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [PC_W-1:0]   skid_pc_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic out_go_s;
    logic in_go_s;
    logic in_keep_s;
    logic load_main_in_s;
    logic load_main_skid_s;
    logic load_skid_s;

    assign out_go_s  = valid_r & down_ready_i & ~stall_i & ~mem_stall_i;
    assign in_go_s   = up_valid_i & up_ready_r;
    assign in_keep_s = in_go_s & ~(DROP_ZERO & (instr_i == {DATA_W{1'b0}}));

    // Next-state and entry-load decode; flush overrides every transition.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush_i) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_keep_s) begin
                        state_nxt_s    = ST_FULL;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_keep_s && out_go_s) begin
                        load_main_in_s = 1'b1;
                    end else if (in_keep_s) begin
                        state_nxt_s = ST_SKID;
                        load_skid_s = 1'b1;
                    end else if (out_go_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (out_go_s) begin
                        state_nxt_s      = ST_FULL;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_SKID;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, entries and registered output decode; the head reads back as BUBBLE when empty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_EMPTY;
            valid_r     <= 1'b0;
            up_ready_r  <= 1'b1;
            main_data_r <= BUBBLE;
            main_pc_r   <= {PC_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            skid_pc_r   <= {PC_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            valid_r    <= (state_nxt_s != ST_EMPTY);
            up_ready_r <= (state_nxt_s != ST_SKID);
            if (state_nxt_s == ST_EMPTY) begin
                main_data_r <= BUBBLE;
                main_pc_r   <= {PC_W{1'b0}};
            end else if (load_main_in_s) begin
                main_data_r <= instr_i;
                main_pc_r   <= pc_i;
            end else if (load_main_skid_s) begin
                main_data_r <= skid_data_r;
                main_pc_r   <= skid_pc_r;
            end
            if (load_skid_s) begin
                skid_data_r <= instr_i;
                skid_pc_r   <= pc_i;
            end
        end
    end

    // Saturating count of flush cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (flush_i && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign up_ready_o   = up_ready_r;
    assign down_valid_o = valid_r;
    assign instr_o      = main_data_r;
    assign pc_o         = main_pc_r;
    assign flush_cnt_o  = flush_cnt_r;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: one instance drops zero payloads, a second keeps them.
module tb_pipe_stage_buf;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              up_valid_i;
    logic [DATA_W-1:0] instr_i;
    logic [PC_W-1:0]   pc_i;
    logic              down_ready_i;
    logic              stall_i;
    logic              mem_stall_i;
    logic              flush_i;

    logic              up_ready_o,   nz_up_ready_o;
    logic              down_valid_o, nz_down_valid_o;
    logic [DATA_W-1:0] instr_o,      nz_instr_o;
    logic [PC_W-1:0]   pc_o,         nz_pc_o;
    logic [CNT_W-1:0]  flush_cnt_o,  nz_flush_cnt_o;

    int tests_run = 0;
    int tests_failed = 0;

    pipe_stage_buf #(.DATA_W(DATA_W), .PC_W(PC_W), .DROP_ZERO(1'b1), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .down_valid_o(down_valid_o), .down_ready_i(down_ready_i),
        .instr_o(instr_o), .pc_o(pc_o), .stall_i(stall_i), .mem_stall_i(mem_stall_i),
        .flush_i(flush_i), .flush_cnt_o(flush_cnt_o)
    );

    pipe_stage_buf #(.DATA_W(DATA_W), .PC_W(PC_W), .DROP_ZERO(1'b0), .CNT_W(CNT_W)) dut_nz (
        .clk_i(clk_i), .rst_i(rst_i), .up_valid_i(up_valid_i), .up_ready_o(nz_up_ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .down_valid_o(nz_down_valid_o), .down_ready_i(down_ready_i),
        .instr_o(nz_instr_o), .pc_o(nz_pc_o), .stall_i(stall_i), .mem_stall_i(mem_stall_i),
        .flush_i(flush_i), .flush_cnt_o(nz_flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] d, input logic [31:0] p);
        up_valid_i = v;
        instr_i    = d;
        pc_i       = p;
    endtask

    task automatic check_head(input string tag, input logic v, input logic [31:0] d,
                              input logic [31:0] p, input logic rdy);
        check_val({tag, "_valid"}, {63'd0, down_valid_o}, {63'd0, v});
        check_val({tag, "_instr"}, {32'd0, instr_o}, {32'd0, d});
        check_val({tag, "_pc"},    {32'd0, pc_o},    {32'd0, p});
        check_val({tag, "_ready"}, {63'd0, up_ready_o}, {63'd0, rdy});
    endtask

    initial begin
        rst_i        = 1'b0;
        up_valid_i   = 1'b0;
        instr_i      = 32'd0;
        pc_i         = 32'd0;
        down_ready_i = 1'b0;
        stall_i      = 1'b0;
        mem_stall_i  = 1'b0;
        flush_i      = 1'b0;
        #12;
        check_head("reset", 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("reset_cnt", {60'd0, flush_cnt_o}, 64'd0);
        tick();
        rst_i = 1'b1;

        // 1: streaming with one cycle latency
        down_ready_i = 1'b1;
        offer(1'b1, 32'h00A00093, 32'h0);
        tick();
        check_head("t1_a", 1'b1, 32'h00A00093, 32'h0, 1'b1);
        offer(1'b1, 32'h00B00113, 32'h4);
        tick();
        check_head("t1_b", 1'b1, 32'h00B00113, 32'h4, 1'b1);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        check_head("t1_drain", 1'b0, 32'h0, 32'h0, 1'b1);

        // 2: stall fills the skid entry and drops up_ready
        stall_i = 1'b1;
        offer(1'b1, 32'h04, 32'h04);
        tick();
        check_head("t2_main", 1'b1, 32'h04, 32'h04, 1'b1);
        offer(1'b1, 32'h08, 32'h08);
        tick();
        check_head("t2_skid", 1'b1, 32'h04, 32'h04, 1'b0);
        offer(1'b1, 32'h0C, 32'h0C);
        tick();
        check_head("t2_hold", 1'b1, 32'h04, 32'h04, 1'b0);
        stall_i = 1'b0;
        tick();
        check_head("t2_rel", 1'b1, 32'h08, 32'h08, 1'b1);
        tick();
        check_head("t2_third", 1'b1, 32'h0C, 32'h0C, 1'b1);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        check_head("t2_drain", 1'b0, 32'h0, 32'h0, 1'b1);

        // 3: flush from SKID
        stall_i = 1'b1;
        offer(1'b1, 32'h14, 32'h14);
        tick();
        offer(1'b1, 32'h18, 32'h18);
        tick();
        check_head("t3_skid", 1'b1, 32'h14, 32'h14, 1'b0);
        offer(1'b0, 32'h0, 32'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        stall_i = 1'b0;
        check_head("t3_flush", 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("t3_cnt", {60'd0, flush_cnt_o}, 64'd1);

        // 4: zero payload dropped vs kept
        offer(1'b1, 32'h0, 32'h10);
        tick();
        check_head("t4_drop", 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("t4_keep_valid", {63'd0, nz_down_valid_o}, 64'd1);
        check_val("t4_keep_instr", {32'd0, nz_instr_o}, 64'd0);
        check_val("t4_keep_pc", {32'd0, nz_pc_o}, 64'h10);
        offer(1'b0, 32'h0, 32'h0);
        tick();
        check_val("t4_keep_drain", {63'd0, nz_down_valid_o}, 64'd0);

        // 5: mem stall holds the head, then counter saturation
        offer(1'b1, 32'h20, 32'h20);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        mem_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_head("t5_memstall", 1'b1, 32'h20, 32'h20, 1'b1);
        end
        mem_stall_i = 1'b0;
        tick();
        check_head("t5_release", 1'b0, 32'h0, 32'h0, 1'b1);
        flush_i = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            tick();
            if (i == 5) check_val("t5_cnt_mid", {60'd0, flush_cnt_o}, 64'd7);
        end
        flush_i = 1'b0;
        check_val("t5_cnt_sat", {60'd0, flush_cnt_o}, 64'hF);

        // 6: asynchronous reset mid-cycle while in SKID
        stall_i = 1'b1;
        offer(1'b1, 32'h30, 32'h30);
        tick();
        offer(1'b1, 32'h34, 32'h34);
        tick();
        check_head("t6_skid", 1'b1, 32'h30, 32'h30, 1'b0);
        offer(1'b0, 32'h0, 32'h0);
        #2;
        rst_i = 1'b0;
        #1;
        check_head("t6_async", 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("t6_cnt", {60'd0, flush_cnt_o}, 64'd0);
        flush_i = 1'b1;
        tick();
        check_val("t6_rst_flush", {60'd0, flush_cnt_o}, 64'd0);
        flush_i = 1'b0;
        rst_i   = 1'b1;
        stall_i = 1'b0;
        offer(1'b1, 32'h40, 32'h40);
        tick();
        check_head("t6_after", 1'b1, 32'h40, 32'h40, 1'b1);
        offer(1'b0, 32'h0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
